// File: rtl/instr_mem_pipe.sv
// Pipelined instruction memory for the IF stage: word-aligned fetch with valid/ready
// handshake, 1- or 2-cycle latency, branch flush, fault reporting and a program-load port.
module instr_mem_pipe #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] NOP       = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_pc,
  input  logic                     flush,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_inst,
  output logic [31:0]              rsp_pc,
  output logic [1:0]               rsp_fault,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_data
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned LAST = LATENCY - 1;

  localparam logic [1:0] FLT_OK    = 2'b00;
  localparam logic [1:0] FLT_MISAL = 2'b01;
  localparam logic [1:0] FLT_RANGE = 2'b10;

  logic [31:0] mem_q [DEPTH];

  logic        vld_q  [LATENCY];
  logic        vld_d  [LATENCY];
  logic [31:0] pc_q   [LATENCY];
  logic [31:0] pc_d   [LATENCY];
  logic [31:0] inst_q [LATENCY];
  logic [31:0] inst_d [LATENCY];
  logic [1:0]  flt_q  [LATENCY];
  logic [1:0]  flt_d  [LATENCY];

  logic          adv;
  logic          accept;
  logic          misal;
  logic          oor;
  logic [1:0]    req_flt;
  logic [AW-1:0] idx;

  // Boot image: zero-filled; reset never touches it.
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (prog_we) mem_q[prog_addr] <= prog_data;
  end

  // Flush forces the pipeline to move so a redirect is never blocked by a stalled consumer.
  assign adv       = !vld_q[LAST] || rsp_ready || flush;
  assign req_ready = rst_n && adv && !prog_we;
  assign accept    = req_valid && req_ready;

  assign misal   = req_pc[1:0] != 2'b00;
  assign oor     = req_pc[31:2] >= 30'(DEPTH);
  assign req_flt = misal ? FLT_MISAL : (oor ? FLT_RANGE : FLT_OK);
  assign idx     = req_pc[AW+1:2];

  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i];
      pc_d[i]   = pc_q[i];
      inst_d[i] = inst_q[i];
      flt_d[i]  = flt_q[i];
    end
    if (adv) begin
      vld_d[0] = accept;
      if (accept) begin
        pc_d[0]   = req_pc;
        flt_d[0]  = req_flt;
        inst_d[0] = (req_flt != FLT_OK) ? NOP : mem_q[idx];
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i]  = vld_q[i-1] && !flush;
        pc_d[i]   = pc_q[i-1];
        inst_d[i] = inst_q[i-1];
        flt_d[i]  = flt_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        pc_q[i]   <= 32'h0;
        inst_q[i] <= 32'h0;
        flt_q[i]  <= FLT_OK;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i]  <= vld_d[i];
        pc_q[i]   <= pc_d[i];
        inst_q[i] <= inst_d[i];
        flt_q[i]  <= flt_d[i];
      end
    end
  end

  assign rsp_valid = vld_q[LAST];
  assign rsp_pc    = pc_q[LAST];
  assign rsp_inst  = inst_q[LAST];
  assign rsp_fault = flt_q[LAST];

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Bench for instr_mem_pipe: LATENCY=1 and LATENCY=2 instances share stimulus and are
// checked against an in-order response scoreboard plus a word-array memory model.
module tb_instr_mem_pipe;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          QD    = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        flush;
  logic        rsp_ready;
  logic        prog_we;
  logic [9:0]  prog_addr;
  logic [31:0] prog_data;

  logic [1:0]       rdy;
  logic [1:0]       rv;
  logic [1:0][31:0] ri;
  logic [1:0][31:0] rp;
  logic [1:0][1:0]  rf;

  always #5 clk = ~clk;

  instr_mem_pipe #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]), .req_pc(req_pc),
    .flush(flush), .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_inst(ri[0]),
    .rsp_pc(rp[0]), .rsp_fault(rf[0]), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  instr_mem_pipe #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]), .req_pc(req_pc),
    .flush(flush), .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_inst(ri[1]),
    .rsp_pc(rp[1]), .rsp_fault(rf[1]), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  int n_tests;
  int n_fail;

  logic [31:0] mem_m  [DEPTH];
  logic [31:0] q_pc   [2][QD];
  logic [31:0] q_inst [2][QD];
  logic [1:0]  q_flt  [2][QD];
  int          q_head [2];
  int          q_cnt  [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fault(input logic [31:0] pc);
    if (pc % 4 != 0) return 2'b01;
    if (pc / 4 >= DEPTH) return 2'b10;
    return 2'b00;
  endfunction

  task automatic set_in(input logic v, input logic [31:0] pc, input logic rr, input logic fl,
                        input logic we, input logic [9:0] a, input logic [31:0] d);
    req_valid = v;
    req_pc    = pc;
    rsp_ready = rr;
    flush     = fl;
    prog_we   = we;
    prog_addr = a;
    prog_data = d;
  endtask

  // One clock: judge the cycle's handshakes against the model, then step across the edge.
  task automatic cycle();
    logic exp_rdy;
    int   slot;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_rdy = rst_n && !(rv[k] && !rsp_ready && !flush) && !prog_we;
      check_eq($sformatf("req_ready_l%0d", k + 1), 32'(rdy[k]), 32'(exp_rdy));
      if (rv[k]) begin
        if (q_cnt[k] == 0) begin
          check_eq($sformatf("spurious_rsp_l%0d", k + 1), 32'(rv[k]), 32'd0);
        end else begin
          check_eq($sformatf("rsp_pc_l%0d", k + 1), rp[k], q_pc[k][q_head[k]]);
          check_eq($sformatf("rsp_inst_l%0d", k + 1), ri[k], q_inst[k][q_head[k]]);
          check_eq($sformatf("rsp_fault_l%0d", k + 1), 32'(rf[k]), 32'(q_flt[k][q_head[k]]));
          if (rsp_ready) begin
            q_head[k] = (q_head[k] + 1) % QD;
            q_cnt[k]--;
          end
        end
      end
      if (flush) q_cnt[k] = 0;
      if (req_valid && rdy[k]) begin
        slot = (q_head[k] + q_cnt[k]) % QD;
        q_pc[k][slot]  = req_pc;
        q_flt[k][slot] = exp_fault(req_pc);
        q_inst[k][slot] = (exp_fault(req_pc) != 2'b00) ? NOP : mem_m[10'(req_pc >> 2)];
        q_cnt[k]++;
      end
    end
    if (prog_we) mem_m[prog_addr] = prog_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    repeat (n) cycle();
  endtask

  initial begin
    int          n_seen;
    logic [31:0] last_pc;
    logic [31:0] pc;
    int          r;

    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 32'h0;
    for (int k = 0; k < 2; k++) begin
      q_head[k] = 0;
      q_cnt[k]  = 0;
    end
    rst_n = 1'b0;
    set_in(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);

    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("reset_req_ready", 32'(rdy[k]), 32'd0);
      check_eq("reset_rsp_valid", 32'(rv[k]), 32'd0);
      check_eq("reset_rsp_inst", ri[k], 32'h0);
      check_eq("reset_rsp_pc", rp[k], 32'h0);
      check_eq("reset_rsp_fault", 32'(rf[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);

    // Program word 0, then single fetch: latency 1 vs 2.
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 10'd0, 32'h0020_81b3);
    cycle();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 10'd1, 32'h0010_0093);
    cycle();
    set_in(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();
    check_eq("lat1_valid", 32'(rv[0]), 32'd1);
    check_eq("lat1_inst", ri[0], 32'h0020_81b3);
    check_eq("lat1_pc", rp[0], 32'h0);
    check_eq("lat1_fault", 32'(rf[0]), 32'd0);
    check_eq("lat2_not_yet", 32'(rv[1]), 32'd0);
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();
    check_eq("lat2_valid", 32'(rv[1]), 32'd1);
    check_eq("lat2_inst", ri[1], 32'h0020_81b3);
    drain(3);

    // Back-to-back fetches, no bubbles.
    for (int j = 0; j < 5; j++) begin
      set_in(j < 3, 32'(4 * j), 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
      cycle();
      check_eq($sformatf("b2b_l1_%0d", j), 32'(rv[0]), 32'(j < 3));
      check_eq($sformatf("b2b_l2_%0d", j), 32'(rv[1]), 32'(j >= 1 && j <= 3));
    end

    // Consumer stall: outputs held, no acceptance.
    set_in(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    repeat (4) cycle();
    for (int k = 0; k < 2; k++) begin
      check_eq("stall_ready", 32'(rdy[k]), 32'd0);
      check_eq("stall_valid", 32'(rv[k]), 32'd1);
      check_eq("stall_pc", rp[k], 32'hC);
    end
    drain(4);

    // Fault cases.
    set_in(1'b1, 32'h6, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();
    check_eq("misal_fault", 32'(rf[0]), 32'd1);
    check_eq("misal_inst", ri[0], NOP);
    set_in(1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();
    check_eq("oor_fault", 32'(rf[0]), 32'd2);
    check_eq("oor_inst", ri[0], NOP);
    set_in(1'b1, 32'hFFC, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();
    check_eq("last_word_fault", 32'(rf[0]), 32'd0);
    drain(3);

    // Program write beats a fetch; the following fetch sees the new word.
    set_in(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 10'd3, 32'hDEAD_BEEF);
    cycle();
    set_in(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();
    check_eq("prog_fetch", ri[0], 32'hDEAD_BEEF);
    drain(3);

    // Flush with two in flight; only the redirect target survives.
    set_in(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();
    set_in(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();
    set_in(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 10'h0, 32'h0);
    cycle();
    for (int k = 0; k < 2; k++) begin
      n_seen  = 0;
      last_pc = 32'hFFFF_FFFF;
      if (k == 1) drain(0);
    end
    n_seen  = 0;
    last_pc = 32'hFFFF_FFFF;
    begin
      int n1;
      logic [31:0] p1;
      n1 = 0;
      p1 = 32'hFFFF_FFFF;
      set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
      for (int j = 0; j < 4; j++) begin
        if (rv[0]) begin n_seen++; last_pc = rp[0]; end
        if (rv[1]) begin n1++; p1 = rp[1]; end
        cycle();
      end
      check_eq("flush_count_l1", 32'(n_seen), 32'd1);
      check_eq("flush_pc_l1", last_pc, 32'h40);
      check_eq("flush_count_l2", 32'(n1), 32'd1);
      check_eq("flush_pc_l2", p1, 32'h40);
    end

    // Async reset mid-stall; memory survives.
    set_in(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();
    cycle();
    check_eq("pre_reset_valid", 32'(rv[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("async_reset_valid", 32'(rv[k]), 32'd0);
      check_eq("async_reset_ready", 32'(rdy[k]), 32'd0);
      q_cnt[k] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();
    check_eq("mem_kept_w3", ri[0], 32'hDEAD_BEEF);
    set_in(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();
    check_eq("mem_kept_w0", ri[0], 32'h0020_81b3);
    drain(3);

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 600; c++) begin
      r = int'($urandom_range(0, 19));
      if (r < 13)       pc = 32'($urandom_range(0, 63)) << 2;
      else if (r < 15)  pc = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else if (r < 17)  pc = ($urandom() | 32'h0000_1000) & 32'hFFFF_FFFC;
      else if (r == 17) pc = 32'hFFC;
      else              pc = 32'h1000;
      set_in($urandom_range(0, 3) != 0, pc, $urandom_range(0, 3) != 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
             ($urandom_range(0, 15) == 0) ? 10'd1023 : 10'($urandom_range(0, 63)),
             $urandom());
      cycle();
    end
    drain(6);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("drain_empty_l%0d", k + 1), 32'(q_cnt[k]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
